// File: rtl/dma_controller.sv
// ---------------------------------------------------------------------------
// dma_controller
//
// Bus-master DMA engine on the CPU's data-memory port. After the CPU hands
// over a base address (cmd_valid/cmd_address), the engine requests the bus
// (BR), waits for the grant (BG), and copies NUM_BLOCKS device blocks into
// memory. Each block write is held for WRITE_LATENCY cycles. It then releases
// the bus and pulses dma_end_interrupt for one cycle.
//
// Ports:
//   clk                system clock, all state changes on posedge
//   reset_n            asynchronous active-low reset
//   cmd_valid          one-cycle strobe, cmd_address valid
//   cmd_address        memory base address of the transfer
//   BR                 bus request to the CPU
//   BG                 bus grant from the CPU
//   dma_end_interrupt  one-cycle completion pulse
//   busy               transfer in progress (through the end pulse)
//   dev_block_idx      block currently requested from the device
//   dev_data           device block data for dev_block_idx (combinational)
//   writeM2            memory write strobe, Z when not bus master
//   address2           memory write address, Z when not bus master
//   data2              memory write data, Z when not bus master
// ---------------------------------------------------------------------------
module dma_controller #(
  parameter int WORD_SIZE       = 16,
  parameter int BLOCK_SIZE      = 64,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_BLOCKS      = 3,
  parameter int WRITE_LATENCY   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  input  logic [WORD_SIZE-1:0]  cmd_address,
  output logic                  BR,
  input  logic                  BG,
  output logic                  dma_end_interrupt,
  output logic                  busy,
  output logic [1:0]            dev_block_idx,
  input  logic [BLOCK_SIZE-1:0] dev_data,
  output logic                  writeM2,
  output logic [WORD_SIZE-1:0]  address2,
  output logic [BLOCK_SIZE-1:0] data2
);

  // Latency counter must hold values up to WRITE_LATENCY-1 (at least 1 bit).
  localparam int LAT_W = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(WRITE_LATENCY - 1);
  localparam logic [1:0]       BLK_LAST = 2'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] base, base_nxt;
  logic [1:0]           blk, blk_nxt;
  logic [LAT_W-1:0]     lat_cnt, lat_nxt;
  logic [WORD_SIZE-1:0] write_addr;
  logic                 drive_bus;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      base    <= '0;
      blk     <= '0;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      base    <= base_nxt;
      blk     <= blk_nxt;
      lat_cnt <= lat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    blk_nxt   = blk;
    lat_nxt   = lat_cnt;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = REQ;
          base_nxt  = cmd_address;
          blk_nxt   = '0;
          lat_nxt   = '0;
        end
      end
      REQ: begin
        if (BG) begin
          state_nxt = WRITE;
          lat_nxt   = '0;
        end
      end
      WRITE: begin
        // Losing the grant aborts the block; it is rewritten in full later.
        if (!BG) begin
          state_nxt = REQ;
          lat_nxt   = '0;
        end else if (lat_cnt == LAT_LAST) begin
          lat_nxt = '0;
          if (blk == BLK_LAST) begin
            state_nxt = DONE;
          end else begin
            blk_nxt = blk + 2'd1;
          end
        end else begin
          lat_nxt = lat_cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        blk_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode directly from the state register, so an asynchronous
  // reset releases the bus immediately without a stray write cycle.
  assign drive_bus  = (state == WRITE);
  assign write_addr = base + (WORD_SIZE'(blk) * WORD_SIZE'(WORDS_PER_BLOCK));

  assign BR                = (state == REQ) || (state == WRITE);
  assign busy              = (state != IDLE);
  assign dma_end_interrupt = (state == DONE);
  assign dev_block_idx     = blk;

  assign writeM2  = drive_bus ? 1'b1       : 1'bz;
  assign address2 = drive_bus ? write_addr : {WORD_SIZE{1'bz}};
  assign data2    = drive_bus ? dev_data   : {BLOCK_SIZE{1'bz}};

endmodule

// File: tb/tb_dma_controller.sv
// ---------------------------------------------------------------------------
// tb_dma_controller
//
// Self-checking bench for dma_controller. A transfer-level reference model
// (transfer requested / bus held / blocks completed / cycles into block)
// predicts every output each cycle. Directed scenarios cover the normal
// transfer, delayed and withdrawn grants, overlapping commands, async reset
// and address wrap; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_dma_controller;

  localparam int WL  = 4;
  localparam int NB  = 3;
  localparam int WPB = 4;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic [15:0] cmd_address;
  logic        BR;
  logic        BG;
  logic        dma_end_interrupt;
  logic        busy;
  logic [1:0]  dev_block_idx;
  logic [63:0] dev_data;
  wire         writeM2;
  wire  [15:0] address2;
  wire  [63:0] data2;

  logic [63:0] dev_table [4];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model of one transfer in progress.
  bit          m_req;
  bit          m_writing;
  bit          m_end;
  logic [15:0] m_base;
  int          m_block;
  int          m_cycles;

  // Observation statistics per scenario.
  logic        prev_w;
  logic [15:0] prev_a;
  logic [15:0] runs[$];
  logic [15:0] exp_runs[$];
  int          cnt_1b;
  int          wcnt;
  int          ends;
  int          first_w;
  int          end_cyc;

  dma_controller dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd_valid         (cmd_valid),
    .cmd_address       (cmd_address),
    .BR                (BR),
    .BG                (BG),
    .dma_end_interrupt (dma_end_interrupt),
    .busy              (busy),
    .dev_block_idx     (dev_block_idx),
    .dev_data          (dev_data),
    .writeM2           (writeM2),
    .address2          (address2),
    .data2             (data2)
  );

  assign dev_data = dev_table[dev_block_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_BR", 64'(BR), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_end", 64'(dma_end_interrupt), 64'd0);
    checkOutput("rst_idx", 64'(dev_block_idx), 64'd0);
    checkOutput("rst_writeM2", {63'd0, writeM2}, {63'd0, 1'bz});
    checkOutput("rst_address2", {48'd0, address2}, {48'd0, 16'hzzzz});
    checkOutput("rst_data2", data2, {64{1'bz}});
  endtask

  task automatic modelReset();
    m_req     = 1'b0;
    m_writing = 1'b0;
    m_end     = 1'b0;
    m_base    = '0;
    m_block   = 0;
    m_cycles  = 0;
  endtask

  // Advances the model across one clock edge given the inputs of that cycle.
  task automatic modelUpdate(input logic cv, input logic [15:0] ca, input logic bg);
    if (m_end) begin
      m_end = 1'b0;
    end else if (!m_req) begin
      if (cv) begin
        m_req     = 1'b1;
        m_base    = ca;
        m_block   = 0;
        m_writing = 1'b0;
      end
    end else if (!m_writing) begin
      if (bg) begin
        m_writing = 1'b1;
        m_cycles  = 0;
      end
    end else if (!bg) begin
      m_writing = 1'b0;
      m_cycles  = 0;
    end else begin
      m_cycles++;
      if (m_cycles == WL) begin
        m_cycles = 0;
        m_block++;
        if (m_block == NB) begin
          m_req     = 1'b0;
          m_writing = 1'b0;
          m_end     = 1'b1;
          m_block   = 0;
        end
      end
    end
  endtask

  task automatic clearStats();
    prev_w  = 1'b0;
    prev_a  = '0;
    runs    = {};
    cnt_1b  = 0;
    wcnt    = 0;
    ends    = 0;
    first_w = -1;
    end_cyc = -1;
    for (int i = 0; i < 4; i++) dev_table[i] = {$urandom, $urandom};
  endtask

  task automatic checkRuns(input string tag);
    checkOutput({tag, "_count"}, 64'(runs.size()), 64'(exp_runs.size()));
    for (int i = 0; i < runs.size() && i < exp_runs.size(); i++)
      checkOutput({tag, "_addr"}, 64'(runs[i]), 64'(exp_runs[i]));
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance model at posedge.
  task automatic applyStimulus(input logic cv, input logic [15:0] ca, input logic bg);
    logic [15:0] exp_addr;
    cmd_valid   = cv;
    cmd_address = ca;
    BG          = bg;
    @(negedge clk);
    checkOutput("BR", 64'(BR), 64'(m_req));
    checkOutput("busy", 64'(busy), 64'(m_req | m_end));
    checkOutput("end_irq", 64'(dma_end_interrupt), 64'(m_end));
    if (m_writing) begin
      exp_addr = m_base + 16'(m_block * WPB);
      checkOutput("writeM2", {63'd0, writeM2}, 64'd1);
      checkOutput("address2", {48'd0, address2}, {48'd0, exp_addr});
      checkOutput("data2", data2, dev_table[m_block]);
      checkOutput("dev_block_idx", 64'(dev_block_idx), 64'(m_block));
    end else begin
      checkOutput("writeM2_z", {63'd0, writeM2}, {63'd0, 1'bz});
      checkOutput("address2_z", {48'd0, address2}, {48'd0, 16'hzzzz});
      checkOutput("data2_z", data2, {64{1'bz}});
    end
    if (writeM2 === 1'b1) begin
      if (!prev_w || address2 !== prev_a) runs.push_back(address2);
      if (first_w < 0) first_w = cyc;
      if (address2 === 16'h001B) cnt_1b++;
      wcnt++;
    end
    if (dma_end_interrupt === 1'b1) begin
      ends++;
      end_cyc = cyc;
    end
    prev_w = (writeM2 === 1'b1);
    prev_a = address2;
    @(posedge clk);
    modelUpdate(cv, ca, bg);
    #1;
    cyc++;
  endtask

  initial begin
    reset_n     = 1'b1;
    cmd_valid   = 1'b0;
    cmd_address = '0;
    BG          = 1'b0;
    modelReset();
    clearStats();
    #1 reset_n = 1'b0;
    #1 checkReset();
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Normal transfer, grant two cycles after BR.
    $display("[TB] normal transfer");
    clearStats();
    applyStimulus(1'b1, 16'h0017, 1'b0);
    repeat (2) applyStimulus(1'b0, 16'h0000, 1'b0);
    repeat (15) applyStimulus(1'b0, 16'h0000, 1'b1);
    exp_runs = '{16'h0017, 16'h001B, 16'h001F};
    checkRuns("normal_runs");
    checkOutput("normal_latency", 64'(end_cyc - first_w), 64'(NB * WL));
    checkOutput("normal_ends", 64'(ends), 64'd1);
    checkOutput("normal_wcnt", 64'(wcnt), 64'(NB * WL));

    // Delayed grant: nothing written while BG is low.
    $display("[TB] delayed grant");
    clearStats();
    applyStimulus(1'b1, 16'h0200, 1'b0);
    repeat (10) applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("delay_no_write", 64'(wcnt), 64'd0);
    repeat (15) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("delay_wcnt", 64'(wcnt), 64'(NB * WL));
    checkOutput("delay_ends", 64'(ends), 64'd1);

    // Grant withdrawn in the 2nd cycle of block 1, re-raised 3 cycles later.
    $display("[TB] grant withdrawn");
    clearStats();
    applyStimulus(1'b1, 16'h0017, 1'b0);
    repeat (6) applyStimulus(1'b0, 16'h0000, 1'b1);
    repeat (3) applyStimulus(1'b0, 16'h0000, 1'b0);
    repeat (12) applyStimulus(1'b0, 16'h0000, 1'b1);
    exp_runs = '{16'h0017, 16'h001B, 16'h001B, 16'h001F};
    checkRuns("abort_runs");
    checkOutput("abort_cnt_1b", 64'(cnt_1b), 64'(2 + WL));
    checkOutput("abort_ends", 64'(ends), 64'd1);

    // Overlapping command during WRITE is ignored.
    $display("[TB] overlapping command");
    clearStats();
    applyStimulus(1'b1, 16'h0017, 1'b0);
    repeat (5) applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 16'h0040, 1'b1);
    repeat (10) applyStimulus(1'b0, 16'h0000, 1'b1);
    repeat (4) applyStimulus(1'b0, 16'h0000, 1'b0);
    exp_runs = '{16'h0017, 16'h001B, 16'h001F};
    checkRuns("overlap_runs");
    checkOutput("overlap_ends", 64'(ends), 64'd1);

    // Asynchronous reset in the middle of block 1.
    $display("[TB] reset mid-transfer");
    clearStats();
    applyStimulus(1'b1, 16'h0017, 1'b0);
    repeat (6) applyStimulus(1'b0, 16'h0000, 1'b1);
    #2 reset_n = 1'b0;
    #1 checkReset();
    modelReset();
    @(posedge clk);
    #1 checkReset();
    reset_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("reset_no_end", 64'(ends), 64'd0);
    clearStats();
    applyStimulus(1'b1, 16'h0100, 1'b0);
    repeat (15) applyStimulus(1'b0, 16'h0000, 1'b1);
    exp_runs = '{16'h0100, 16'h0104, 16'h0108};
    checkRuns("after_reset_runs");
    checkOutput("after_reset_ends", 64'(ends), 64'd1);

    // Address wrap modulo 2^16.
    $display("[TB] address wrap");
    clearStats();
    applyStimulus(1'b1, 16'hFFFE, 1'b0);
    repeat (15) applyStimulus(1'b0, 16'h0000, 1'b1);
    exp_runs = '{16'hFFFE, 16'h0002, 16'h0006};
    checkRuns("wrap_runs");

    // Randomized phase: sporadic commands, mostly-granted bus, spurious BG.
    $display("[TB] random phase");
    clearStats();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), 16'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
